// File: rtl/prog_launch_pkg.sv
// Shared types and constants for the program launch controller.
package prog_launch_pkg;

   // Launch sequencer states
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_RESET_HOLD = 2'd1,
      ST_RUN        = 2'd2
   } launch_state_e;

   localparam logic [15:0] PROG_BASE   = 16'hC000;
   localparam logic [15:0] PROG_STRIDE = 16'h0100;

   // Entry address of a program slot: base plus one stride per slot
   function automatic logic [15:0] prog_start_addr(input logic [3:0] prog);
      prog_start_addr = PROG_BASE + (PROG_STRIDE * {12'd0, prog});
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, counter debounce and a
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic rise_evt
);

   localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q,  sync_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             level_q, level_d;
   logic             evt_q,   evt_d;

   // Synchronizer shift, debounce counter and rising-edge detection
   always_comb begin
      sync_d  = {sync_q[0], btn_raw};
      cnt_d   = '0;
      level_d = level_q;
      evt_d   = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            evt_d   = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         evt_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         evt_q   <= evt_d;
      end
   end

   assign rise_evt = evt_q;

endmodule

// File: rtl/prog_launch_ctrl.sv
// Program launch controller: on a debounced start press, latches the
// selected program slot, holds the CPU in reset for a fixed pulse, then
// lets it run. Out-of-range selections are rejected with a one-cycle error.
module prog_launch_ctrl
   import prog_launch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES    = 270000,
   parameter int unsigned RESET_PULSE_CYCLES = 64,
   parameter int unsigned NUM_PROGRAMS       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  program_select,
   input  logic        start_btn,
   output logic        cpu_reset,
   output logic [15:0] start_address,
   output logic [3:0]  current_program,
   output logic        program_running,
   output logic        sel_error
);

   localparam int unsigned         HOLD_W    = $clog2(RESET_PULSE_CYCLES);
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RESET_PULSE_CYCLES - 1);
   localparam logic [4:0]          NUM_PROG  = 5'(NUM_PROGRAMS);

   logic            start_evt;
   logic            sel_valid;

   logic [3:0]        sel_meta_q,  sel_meta_d;
   logic [3:0]        sel_sync_q,  sel_sync_d;
   launch_state_e     state_q,     state_d;
   logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
   logic [3:0]        prog_q,      prog_d;
   logic [15:0]       addr_q,      addr_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              running_q,   running_d;
   logic              sel_err_q,   sel_err_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_start_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (start_btn),
      .rise_evt (start_evt)
   );

   assign sel_valid = ({1'b0, sel_sync_q} < NUM_PROG);

   // Select synchronizer, launch sequencing and registered output values
   always_comb begin
      sel_meta_d = program_select;
      sel_sync_d = sel_meta_q;
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      prog_d     = prog_q;
      addr_d     = addr_q;
      sel_err_d  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_RUN: begin
            if (start_evt) begin
               if (sel_valid) begin
                  state_d    = ST_RESET_HOLD;
                  hold_cnt_d = HOLD_LAST;
                  prog_d     = sel_sync_q;
                  addr_d     = prog_start_addr(sel_sync_q);
               end else begin
                  sel_err_d = 1'b1;
               end
            end
         end
         ST_RESET_HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs follow the next state so they change on the transition edge
      cpu_reset_d = (state_d != ST_RUN);
      running_d   = (state_d == ST_RUN);
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_meta_q  <= '0;
         sel_sync_q  <= '0;
         state_q     <= ST_IDLE;
         hold_cnt_q  <= '0;
         prog_q      <= '0;
         addr_q      <= PROG_BASE;
         cpu_reset_q <= 1'b1;
         running_q   <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         sel_meta_q  <= sel_meta_d;
         sel_sync_q  <= sel_sync_d;
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         prog_q      <= prog_d;
         addr_q      <= addr_d;
         cpu_reset_q <= cpu_reset_d;
         running_q   <= running_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign cpu_reset       = cpu_reset_q;
   assign start_address   = addr_q;
   assign current_program = prog_q;
   assign program_running = running_q;
   assign sel_error       = sel_err_q;

endmodule

// File: tb/tb_prog_launch_ctrl.sv
// Self-checking bench for prog_launch_ctrl with a behavioural reference model.
module tb_prog_launch_ctrl;

   localparam int D = 4;
   localparam int P = 8;
   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  program_select = 4'd0;
   logic        start_btn = 1'b0;
   logic        cpu_reset;
   logic [15:0] start_address;
   logic [3:0]  current_program;
   logic        program_running;
   logic        sel_error;

   int checks = 0;
   int errors = 0;

   prog_launch_ctrl #(
      .DEBOUNCE_CYCLES    (D),
      .RESET_PULSE_CYCLES (P),
      .NUM_PROGRAMS       (N)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .program_select  (program_select),
      .start_btn       (start_btn),
      .cpu_reset       (cpu_reset),
      .start_address   (start_address),
      .current_program (current_program),
      .program_running (program_running),
      .sel_error       (sel_error)
   );

   always #5 clk = ~clk;

   // Reference model: inputs seen two edges late, a run of D differing
   // samples flips the button level, a rising level launches one cycle later.
   bit        mb1 = 0, mb2 = 0;
   bit [3:0]  ms1 = 0, ms2 = 0;
   int        m_run = 0;
   bit        m_level = 0, m_evt = 0;
   int        m_phase = 0;      // 0 idle, 1 holding CPU in reset, 2 running
   int        m_hold_done = 0;
   bit [3:0]  m_prog = 0;
   bit [15:0] m_addr = 16'hC000;
   bit        m_err = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mb1 = 0; mb2 = 0; ms1 = 0; ms2 = 0;
         m_run = 0; m_level = 0; m_evt = 0;
         m_phase = 0; m_hold_done = 0; m_prog = 0; m_addr = 16'hC000; m_err = 0;
      end else begin
         m_err = 1'b0;
         if (m_phase == 1) begin
            m_hold_done++;
            if (m_hold_done == P) m_phase = 2;
         end else if (m_evt) begin
            if (int'(ms2) < N) begin
               m_prog = ms2;
               m_addr = 16'(32'hC000 + 32'(ms2) * 32'h100);
               m_phase = 1;
               m_hold_done = 0;
            end else begin
               m_err = 1'b1;
            end
         end
         m_evt = 1'b0;
         if (mb2 != m_level) begin
            m_run++;
            if (m_run == D) begin
               m_level = mb2;
               m_run = 0;
               m_evt = mb2;
            end
         end else begin
            m_run = 0;
         end
         mb2 = mb1; mb1 = start_btn;
         ms2 = ms1; ms1 = program_select;
      end
   end

   logic [22:0] dut_v, mdl_v;
   assign dut_v = {cpu_reset, program_running, sel_error, current_program, start_address};
   assign mdl_v = {(m_phase != 2), (m_phase == 2), m_err, m_prog, m_addr};

   task automatic test_reset();
      #1 rst_n = 1'b0;
      start_btn = 1'b0;
      program_select = 4'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (dut_v !== {1'b1, 1'b0, 1'b0, 4'd0, 16'hC000}) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", dut_v, {1'b1, 1'b0, 1'b0, 4'd0, 16'hC000});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         program_select = 4'($urandom);
         @(negedge clk);
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL reset_idle_model cyc=%0d got=%h exp=%h", i, dut_v, mdl_v);
         end
         checks++;
         if (cpu_reset !== 1'b1 || program_running !== 1'b0 || start_address !== 16'hC000) begin
            errors++;
            $display("FAIL reset_idle_hold cyc=%0d got=%h exp cpu_reset=1 running=0 addr=c000", i, dut_v);
         end
      end
   endtask

   task automatic test_clean_launch();
      int cyc = 0;
      program_select = 4'd3;
      start_btn = 1'b1;
      while (program_running !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL launch_model cyc=%0d got=%h exp=%h", cyc, dut_v, mdl_v);
         end
      end
      checks++;
      if (cyc != 2 + D + 1 + P) begin
         errors++;
         $display("FAIL launch_latency got=%0d exp=%0d", cyc, 2 + D + 1 + P);
      end
      checks++;
      if (start_address !== 16'hC300 || current_program !== 4'd3) begin
         errors++;
         $display("FAIL launch_latch got addr=%h prog=%0d exp addr=c300 prog=3", start_address, current_program);
      end
      start_btn = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL launch_release cyc=%0d got=%h exp=%h", i, dut_v, mdl_v);
         end
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 50; i++) begin
         start_btn = (i < 40) ? ~1'((i / 2) % 2) : 1'b0;
         program_select = 4'($urandom);
         @(negedge clk);
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL bounce_model cyc=%0d got=%h exp=%h", i, dut_v, mdl_v);
         end
         checks++;
         if (dut_v !== {1'b0, 1'b1, 1'b0, 4'd3, 16'hC300}) begin
            errors++;
            $display("FAIL bounce_stable cyc=%0d got=%h exp=%h", i, dut_v, {1'b0, 1'b1, 1'b0, 4'd3, 16'hC300});
         end
      end
   endtask

   task automatic test_relaunch();
      int cyc = 0;
      int hcnt = 0;
      int guard = 0;
      program_select = 4'd5;
      repeat (3) @(negedge clk);
      start_btn = 1'b1;
      while (cpu_reset !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL relaunch_model cyc=%0d got=%h exp=%h", cyc, dut_v, mdl_v);
         end
      end
      checks++;
      if (cyc != 2 + D + 1) begin
         errors++;
         $display("FAIL relaunch_latency got=%0d exp=%0d", cyc, 2 + D + 1);
      end
      do begin
         if (cpu_reset === 1'b1) hcnt++;
         @(negedge clk);
         guard++;
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL relaunch_hold_model cyc=%0d got=%h exp=%h", guard, dut_v, mdl_v);
         end
      end while (cpu_reset === 1'b1 && guard < 50);
      checks++;
      if (hcnt != P) begin
         errors++;
         $display("FAIL relaunch_hold_len got=%0d exp=%0d", hcnt, P);
      end
      checks++;
      if (dut_v !== {1'b0, 1'b1, 1'b0, 4'd5, 16'hC500}) begin
         errors++;
         $display("FAIL relaunch_run got=%h exp=%h", dut_v, {1'b0, 1'b1, 1'b0, 4'd5, 16'hC500});
      end
      start_btn = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_bad_select();
      int pulses = 0;
      program_select = 4'd9;
      repeat (3) @(negedge clk);
      start_btn = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (sel_error === 1'b1) pulses++;
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL badsel_model cyc=%0d got=%h exp=%h", i, dut_v, mdl_v);
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL badsel_pulse got=%0d pulses exp=1", pulses);
      end
      checks++;
      if ({cpu_reset, program_running, current_program, start_address} !== {1'b0, 1'b1, 4'd5, 16'hC500}) begin
         errors++;
         $display("FAIL badsel_unchanged got=%h exp run prog=5 addr=c500", dut_v);
      end
      start_btn = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_press_during_hold();
      int hcnt = 0;
      int pulses = 0;
      logic [3:0] second_sel;
      second_sel = ($urandom_range(0, 1) == 0) ? 4'd6 : 4'd12;
      program_select = 4'd2;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         if (i == 0) start_btn = 1'b1;
         if (i == 4) start_btn = 1'b0;
         if (i == 8) begin
            start_btn = 1'b1;
            program_select = second_sel;
         end
         @(negedge clk);
         if (cpu_reset === 1'b1) hcnt++;
         if (sel_error === 1'b1) pulses++;
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL hold_ignore_model cyc=%0d got=%h exp=%h", i, dut_v, mdl_v);
         end
      end
      checks++;
      if (hcnt != P || pulses != 0) begin
         errors++;
         $display("FAIL hold_ignore_len got hold=%0d err=%0d exp hold=%0d err=0", hcnt, pulses, P);
      end
      checks++;
      if (dut_v !== {1'b0, 1'b1, 1'b0, 4'd2, 16'hC200}) begin
         errors++;
         $display("FAIL hold_ignore_latch got=%h exp=%h", dut_v, {1'b0, 1'b1, 1'b0, 4'd2, 16'hC200});
      end
      start_btn = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid_hold();
      int cyc = 0;
      program_select = 4'd4;
      repeat (3) @(negedge clk);
      start_btn = 1'b1;
      while (cpu_reset !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cpu_reset !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_enter got cpu_reset=%b exp 1 within 50 cycles", cpu_reset);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (dut_v !== {1'b1, 1'b0, 1'b0, 4'd0, 16'hC000}) begin
         errors++;
         $display("FAIL rstmid_async got=%h exp=%h", dut_v, {1'b1, 1'b0, 1'b0, 4'd0, 16'hC000});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_btn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (dut_v !== mdl_v || dut_v !== {1'b1, 1'b0, 1'b0, 4'd0, 16'hC000}) begin
            errors++;
            $display("FAIL rstmid_idle cyc=%0d got=%h exp=%h", i, dut_v, {1'b1, 1'b0, 1'b0, 4'd0, 16'hC000});
         end
      end
      start_btn = 1'b1;
      cyc = 0;
      while (program_running !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL rstmid_relaunch_model cyc=%0d got=%h exp=%h", cyc, dut_v, mdl_v);
         end
      end
      checks++;
      if (cyc != 2 + D + 1 + P || start_address !== 16'hC400 || current_program !== 4'd4) begin
         errors++;
         $display("FAIL rstmid_relaunch got cyc=%0d addr=%h prog=%0d exp cyc=%0d addr=c400 prog=4",
                  cyc, start_address, current_program, 2 + D + 1 + P);
      end
      start_btn = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_random();
      int seg = 0;
      for (int i = 0; i < 1500; i++) begin
         if (seg == 0) begin
            start_btn = 1'($urandom_range(0, 1));
            seg = $urandom_range(1, 9);
         end
         seg--;
         if ($urandom_range(0, 7) == 0) program_select = 4'($urandom);
         if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
         @(negedge clk);
         checks++;
         if (dut_v !== mdl_v) begin
            errors++;
            $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_v, mdl_v);
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clean_launch();
      test_bounce();
      test_relaunch();
      test_bad_select();
      test_press_during_hold();
      test_reset_mid_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
